// File: rtl/mfe_led7seg_74hc595_demo_1.sv
// Button-driven BCD counter shown on a 4-digit display through two 74HC595s.
// Optional macro LED7SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module mfe_led7seg_74hc595_demo_1 #(
  parameter int SCLK_DIV        = 1,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic sclk,
  output logic rclk,
  output logic dio
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  function automatic logic [7:0] segcode(input logic [3:0] d);
    case (d)
      4'd0:    segcode = 8'hC0;
      4'd1:    segcode = 8'hF9;
      4'd2:    segcode = 8'hA4;
      4'd3:    segcode = 8'hB0;
      4'd4:    segcode = 8'h99;
      4'd5:    segcode = 8'h92;
      4'd6:    segcode = 8'h82;
      4'd7:    segcode = 8'hF8;
      4'd8:    segcode = 8'h80;
      4'd9:    segcode = 8'h90;
      default: segcode = 8'hFF;
    endcase
  endfunction

  logic          s1, s2, deb, inc;
  logic [CW-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      inc  <= 1'b0;
      dcnt <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      inc <= 1'b0;
      if (s2 != deb) begin
        if (dcnt == DEB_LAST) begin
          deb  <= s2;
          dcnt <= '0;
          inc  <= s2;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  // bcd[0] is thousands, bcd[3] is units
  logic [3:0][3:0] bcd, nxt;
  logic            carry;

  always_comb begin
    nxt   = bcd;
    carry = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          nxt[i] = 4'd0;
        end else begin
          nxt[i] = bcd[i] + 4'd1;
          carry  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      bcd <= '0;
    else if (inc) bcd <= nxt;
  end

  logic [1:0] idx;
  logic [3:0] dval;
  logic [7:0] seg, sel;

  assign dval = bcd[idx];
  assign sel  = 8'hF0 | (8'h01 << idx);

`ifdef LED7SEG_BLANK_LEADING_ZERO_EN
  logic lz;
  always_comb begin
    lz = 1'b1;
    for (int i = 0; i < 4; i++)
      if (i <= int'(idx) && bcd[i] != 4'd0) lz = 1'b0;
    seg = (lz && idx != 2'd3) ? 8'hFF : segcode(dval);
  end
`else
  assign seg = segcode(dval);
`endif

  state_t        state;
  logic [15:0]   word;
  logic [3:0]    ptr;
  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      sclk  <= 1'b0;
      rclk  <= 1'b0;
      dio   <= 1'b0;
      word  <= '0;
      ptr   <= '0;
      div   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          word  <= {seg, sel};
          ptr   <= 4'd15;
          dio   <= seg[7];
          sclk  <= 1'b0;
          rclk  <= 1'b0;
          div   <= '0;
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div == DIV_LAST) begin
            div  <= '0;
            sclk <= 1'b0;
            if (ptr == 4'd0) begin
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              ptr   <= ptr - 4'd1;
              dio   <= word[ptr - 4'd1];
              state <= SHIFT_LO;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        LATCH: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            rclk  <= 1'b0;
            idx   <= idx + 2'd1;
            state <= LOAD;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mfe_led7seg_74hc595_demo_1.sv
// Scoreboard bench: latched 16-bit frames are compared against a model
// computed from the expected counter value and the frame's digit index.
module tb_mfe_led7seg_74hc595_demo_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic sclk, rclk, dio;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  bit          mon_en = 1'b1;

  always #5 clk = ~clk;

  mfe_led7seg_74hc595_demo_1 #(.SCLK_DIV(1), .DEBOUNCE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .sclk(sclk),
    .rclk(rclk),
    .dio (dio)
  );

  function automatic logic [7:0] segref(input logic [3:0] d);
    logic [7:0] t[10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] c, input int k);
    logic [3:0] d;
    logic [7:0] s;
    logic       lz;
    d  = c[15 - 4 * k -: 4];
    lz = 1'b1;
    for (int j = 0; j <= k; j++)
      if (c[15 - 4 * j -: 4] != 4'd0) lz = 1'b0;
    s = segref(d);
`ifdef LED7SEG_BLANK_LEADING_ZERO_EN
    if (lz && k != 3) s = 8'hFF;
`else
    if (lz && k > 3) s = 8'h00;
`endif
    return {s, 8'hF0 | (8'h01 << k)};
  endfunction

  // Monitor: shifts dio on sclk rise, compares on rclk rise.
  logic [15:0] sr;
  int          nb, midx;
  logic        ps, pr;

  always @(negedge clk) begin
    logic [15:0] c, e;
    if (rst) begin
      sr = '0; nb = 0; midx = 0; ps = 1'b0; pr = 1'b0;
    end else begin
      checks++;
      if (sclk === 1'b1 && rclk === 1'b1) begin
        failures++;
        $display("FAIL overlap sclk=%b rclk=%b required not both 1", sclk, rclk);
      end
      if (sclk === 1'b1 && ps === 1'b0) begin
        sr = {sr[14:0], dio};
        nb++;
      end
      if (rclk === 1'b1 && pr === 1'b0) begin
        if (mon_en) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL frame unexpected latch got=%h bits=%0d", sr, nb);
          end else begin
            c = q.pop_front();
            e = exp_word(c, midx);
            if (sr !== e || nb != 16) begin
              failures++;
              $display("FAIL frame idx=%0d count=%h got=%h bits=%0d exp=%h bits=16",
                       midx, c, sr, nb, e);
            end
          end
        end
        nb   = 0;
        sr   = '0;
        midx = (midx + 1) % 4;
      end
      ps = sclk;
      pr = rclk;
    end
  end

  task automatic push_frames(input int v, input int n);
    repeat (n) q.push_back(to_bcd(v));
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (q.size() != 0 && t < n * 40 + 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain timeout left=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_rclk(input logic lvl);
    int t;
    t = 0;
    while (rclk !== lvl && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (rclk !== lvl) begin
      checks++;
      failures++;
      $display("FAIL rclk wait got=%b required %b", rclk, lvl);
    end
  endtask

  // Realign to a frame boundary, then expect 4 frames of value v.
  task automatic resync(input int v);
    wait_rclk(1'b0);
    wait_rclk(1'b1);
    @(negedge clk);
    push_frames(v, 4);
    mon_en = 1'b1;
    drain(4);
  endtask

  task automatic press(input int hi, input int lo);
    @(negedge clk);
    btn = 1'b1;
    repeat (hi) @(negedge clk);
    btn = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_out(input string nm);
    checks++;
    if (sclk !== 1'b0 || rclk !== 1'b0 || dio !== 1'b0) begin
      failures++;
      $display("FAIL %s sclk=%b rclk=%b dio=%b required 0 0 0", nm, sclk, rclk, dio);
    end
  endtask

  initial begin
    rst = 1'b1;
    push_frames(0, 8);
    @(negedge clk); chk_out("reset_a");
    @(negedge clk); chk_out("reset_b");
    @(negedge clk);
    rst = 1'b0;
    drain(8);

    mon_en = 1'b0;
    press(3, 5);
    press(2, 10);
    resync(2);

    mon_en = 1'b0;
    press(1, 12);
    resync(2);

    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); chk_out("midframe_rst");
    @(negedge clk); chk_out("midframe_rst_hold");
    rst = 1'b0;
    push_frames(0, 4);
    drain(4);

    mon_en = 1'b0;
    repeat (7) press(2, 2);
    repeat (10) @(negedge clk);
    resync(7);

    mon_en = 1'b0;
    repeat (9992) press(2, 2);
    repeat (10) @(negedge clk);
    resync(9999);

    mon_en = 1'b0;
    press(2, 10);
    resync(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfe_led7seg_74hc595_demo_1.md
Name: mfe_led7seg_74hc595_demo_1

Overview:
- Demo top for the multi-function-shield 4-digit 7-segment display, driven through two cascaded 74HC595 shift registers.
- A push button increments a 4-digit BCD counter, range 0000–9999.
- The counter is shown by time-multiplexing one digit per serial frame on sclk/rclk/dio.
- Standalone board-level block: button input, three serial pins out.

Parameters:
- SCLK_DIV, 1: clk cycles per sclk half-period (≥1).
- DEBOUNCE_CYCLES, 2: consecutive stable synchronized samples needed to accept a new button level (≥1).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous reset, active-high.
- btn  input  1  raw push button, active-high, asynchronous to clk.
- sclk  output  1  74HC595 shift clock; data is sampled on its rising edge.
- rclk  output  1  74HC595 storage/latch clock; rising edge transfers the shift register to the outputs.
- dio  output  1  74HC595 serial data.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on rising clk).
- Values while rst is high: sclk=0, rclk=0, dio=0, counter=0000, digit index=0, synchronizer and debouncer cleared to 0, FSM=LOAD.
- Reset mid-frame aborts the frame immediately; no latch pulse is issued.
- Button path: 2-FF synchronizer → debouncer.
  - Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A debounced 0→1 edge increments the counter by exactly 1 on the following cycle.
  - Release and glitches shorter than DEBOUNCE_CYCLES never count.
- Counter: 4 BCD digits (thousands..units).
  - Units 9 carries into tens, and so on through thousands.
  - 9999+1 wraps to 0000.
- Frame word, 16 bits: {seg[7:0], sel[7:0]}, shifted MSB first, so seg ends in the far 74HC595.
  - seg: active-low, bit7=dp (always 1/off), bits6..0 = g,f,e,d,c,b,a.
  - Codes for 0..9: C0 F9 A4 B0 99 92 82 F8 80 90 (hex).
  - sel = 0xF0 | (1<<digit); digit 0 = thousands (0xF1), 3 = units (0xF8).
- FSM:
  - LOAD (1 cycle): snapshot the counter digit for the current index, build the word, bit pointer=15, dio=word[15], sclk=0, rclk=0.
  - SHIFT_LO (SCLK_DIV cycles): sclk=0, dio holds the current bit.
  - SHIFT_HI (SCLK_DIV cycles): sclk=1. Then, if the bit pointer is 0 → LATCH; otherwise decrement the pointer, update dio, → SHIFT_LO.
  - LATCH (SCLK_DIV cycles): sclk=0, rclk=1. Then rclk=0, digit index = (index+1) mod 4, → LOAD.
- Frame length is 1 + 33·SCLK_DIV cycles (34 at the default).
- dio changes only while sclk=0; rclk is never high while sclk=1.
- Counter increments during a frame do not alter that frame; they appear from the next LOAD onward.
- Simultaneous increment and LOAD in the same cycle: LOAD uses the pre-increment value.

Optional Feature:
- Macro: LED7SEG_BLANK_LEADING_ZERO_EN.
- Defined: leading zero digits output seg=0xFF (blank); the units digit is always displayed. Example: 0042 shows blank, blank, 4, 2.
- Undefined: all four digits are always displayed, leading zeros included.
- Frame timing and sel values are identical in both builds.

Test Plan:
- Reset then idle, btn=0, SCLK_DIV=1 → first frame (34 cycles) shifts 0xC0F1 MSB first, then one rclk pulse. The next three frames carry 0xC0F2, 0xC0F4, 0xC0F8, then the sequence repeats.
- btn high for 3 cycles, low 5, high 2 (DEBOUNCE_CYCLES=2) → counter = 0002; the units frame shifts 0xA4F8.
- btn pulse of 1 cycle → no increment; all frames still show 0000.
- Preload 9999 via repeated presses, press once more → wraps; frames return to 0xC0F1 / 0xC0F2 / 0xC0F4 / 0xC0F8.
- Assert rst mid-shift → the next cycle has sclk=rclk=dio=0; no rclk pulse for the aborted frame; the counter reads 0000 afterwards.
- With LED7SEG_BLANK_LEADING_ZERO_EN defined and counter=0007 → frames 0xFFF1, 0xFFF2, 0xFFF4, 0xF8F8.
